// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 4-bit CPU.
// Owns PC, IR, carry flag, jump handling and register write strobes.
//
// Ports:
//   clk, n_reset            clock (rising edge), async active-low reset
//   run, step               continuous-run level / single-step pulse
//   rom_en, rom_addr        program ROM read request (addr = pc)
//   rom_data                ROM data, valid one cycle after rom_en
//   op_out, im_out          IR[7:4] to decoder, IR[3:0] to ALU
//   dec_reg_a_load/_b_load  decoder load controls for op_out
//   alu_carry               ALU carry-out for current op/im
//   reg_a_we, reg_b_we      one-cycle register write strobes
//   carry_flag, pc          architectural state
//   busy, instr_done        status: not idle / last cycle of instruction

`ifndef OP_JNC
`define OP_JNC 4'hE
`endif
`ifndef OP_JMP
`define OP_JMP 4'hF
`endif

module cpu_sequencer #(
    parameter int unsigned     PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            run,
    input  logic            step,
    output logic            rom_en,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    output logic [3:0]      op_out,
    output logic [3:0]      im_out,
    input  logic            dec_reg_a_load,
    input  logic            dec_reg_b_load,
    input  logic            alu_carry,
    output logic            reg_a_we,
    output logic            reg_b_we,
    output logic            carry_flag,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            instr_done
);

    localparam logic [3:0] C_OP_JMP = `OP_JMP;
    localparam logic [3:0] C_OP_JNC = `OP_JNC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic            r_carry;
    logic            r_step;

    logic            w_exec;
    logic            w_load;
    logic [PC_W-1:0] w_jmp_tgt;
    logic [PC_W-1:0] w_pc_next;

    assign w_exec    = (r_state == S_EXEC);
    assign w_load    = dec_reg_a_load | dec_reg_b_load;
    // Immediate is zero-extended (or truncated) to the PC width.
    assign w_jmp_tgt = PC_W'(r_ir[3:0]);

    always_comb begin
        w_pc_next = r_pc + PC_W'(1);
        unique case (1'b1)
            (r_ir[7:4] == C_OP_JMP): w_pc_next = w_jmp_tgt;
            (r_ir[7:4] == C_OP_JNC): begin
                if (!r_carry) w_pc_next = w_jmp_tgt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_carry <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (run || step) begin
                        r_state <= S_FETCH;
                        // run takes priority over a coincident step
                        r_step  <= step & ~run;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir    <= rom_data;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_load) r_carry <= alu_carry;
                    // JNC consumes the flag whether or not it jumps
                    if (r_ir[7:4] == C_OP_JNC) r_carry <= 1'b0;
                    r_pc <= w_pc_next;
                    if (run && !r_step) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                        r_step  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode the state register directly so an async reset
    // removes them in the same cycle.
    assign rom_en     = (r_state == S_FETCH);
    assign rom_addr   = rom_en ? r_pc : '0;
    assign op_out     = r_ir[7:4];
    assign im_out     = r_ir[3:0];
    assign reg_a_we   = w_exec & dec_reg_a_load;
    assign reg_b_we   = w_exec & dec_reg_b_load;
    assign instr_done = w_exec;
    assign busy       = (r_state != S_IDLE);
    assign carry_flag = r_carry;
    assign pc         = r_pc;

endmodule
